// File: rtl/gpu_pll_supervisor.sv
// ============================================================================
// Module   : gpu_pll_supervisor
// Brief    : PLL reset sequencer, lock qualifier and retry supervisor that
//            holds the PLL-clocked domain in reset until lock is trusted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_pll_supervisor #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 256,
    parameter int RETRY_LIMIT  = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       domain_rst,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int c_MAX_RT  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int c_MAX_ALL = (c_MAX_RT > LOCK_STABLE) ? c_MAX_RT : LOCK_STABLE;
    localparam int c_CNT_W   = $clog2(c_MAX_ALL) + 1;

    localparam logic [c_CNT_W-1:0] c_RESET_LAST   = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]         c_RETRY_LIMIT  = 4'(RETRY_LIMIT);

    localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABILIZE = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAILED    = 3'd4;

    logic               r_sync;
    logic               r_locked_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    logic [2:0]         w_state_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic [3:0]         w_retry_nx;
    logic               w_lock_lost_nx;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt + 1'b1;
        w_retry_nx     = retry_count;
        w_lock_lost_nx = 1'b0;
        if (restart) begin
            w_state_nx = c_ST_RESET_PLL;
            w_cnt_nx   = '0;
            w_retry_nx = 4'd0;
        end else begin
            case (r_state)
                c_ST_RESET_PLL: begin
                    if (r_cnt == c_RESET_LAST) begin
                        w_state_nx = c_ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nx = c_ST_STABILIZE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_cnt_nx = '0;
                        if (retry_count == c_RETRY_LIMIT) begin
                            w_state_nx = c_ST_FAILED;
                        end else begin
                            w_state_nx = c_ST_RESET_PLL;
                            w_retry_nx = retry_count + 4'd1;
                        end
                    end
                end
                c_ST_STABILIZE: begin
                    // Any drop during the window restarts the full lock timeout.
                    if (!r_locked_s) begin
                        w_state_nx = c_ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nx = c_ST_RUN;
                        w_cnt_nx   = '0;
                        w_retry_nx = 4'd0;
                    end
                end
                c_ST_RUN: begin
                    w_cnt_nx = '0;
                    if (!r_locked_s) begin
                        w_state_nx     = c_ST_RESET_PLL;
                        w_lock_lost_nx = 1'b1;
                    end
                end
                c_ST_FAILED: begin
                    w_cnt_nx = '0;
                end
                default: begin
                    w_state_nx = c_ST_RESET_PLL;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync      <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= c_ST_RESET_PLL;
            r_cnt       <= '0;
            pll_rst     <= 1'b1;
            domain_rst  <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            r_sync      <= locked;
            r_locked_s  <= r_sync;
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            pll_rst     <= (w_state_nx == c_ST_RESET_PLL) || (w_state_nx == c_ST_FAILED);
            domain_rst  <= (w_state_nx != c_ST_RUN);
            ready       <= (w_state_nx == c_ST_RUN);
            fail        <= (w_state_nx == c_ST_FAILED);
            lock_lost   <= w_lock_lost_nx;
            retry_count <= w_retry_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpu_pll_supervisor.sv
// ============================================================================
// Module   : tb_gpu_pll_supervisor
// Brief    : Directed vector bench for gpu_pll_supervisor (4/20/8/2 config).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_pll_supervisor;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       restart;
    logic       pll_rst;
    logic       domain_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    gpu_pll_supervisor #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .RETRY_LIMIT  (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .domain_rst  (domain_rst),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        string      name;
        bit         rst;
        bit         locked;
        bit         restart;
        int         cycles;
        logic [8:0] exp;   // {pll_rst, domain_rst, ready, fail, lock_lost, retry_count}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input bit r, input bit l, input bit rs, input int n,
                       input bit p, input bit d, input bit rd, input bit f, input bit ll,
                       input int rc);
        vec_t v;
        v.name    = nm;
        v.rst     = r;
        v.locked  = l;
        v.restart = rs;
        v.cycles  = n;
        v.exp     = {p, d, rd, f, ll, 4'(rc)};
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {pll_rst, domain_rst, ready, fail, lock_lost, retry_count};
    endfunction

    initial begin
        int n;
        rst     = 1'b1;
        locked  = 1'b0;
        restart = 1'b0;

        //  name                 rst lck rstrt cyc  pll dr rdy fl ll rc
        add("t1_reset",           1,  0,  0,   2,   1,  1, 0,  0, 0, 0);
        add("t1_pll_hold",        0,  0,  0,   3,   1,  1, 0,  0, 0, 0);
        add("t1_pll_fall",        0,  0,  0,   1,   0,  1, 0,  0, 0, 0);
        add("t1_wait",            0,  0,  0,   5,   0,  1, 0,  0, 0, 0);
        add("t1_pre_ready",       0,  1,  0,  10,   0,  1, 0,  0, 0, 0);
        add("t1_ready",           0,  1,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t5_glitch",          0,  0,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t5_sync",            0,  1,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t5_lost",            0,  1,  0,   1,   1,  1, 0,  0, 1, 0);
        add("t5_pulse_single",    0,  1,  0,   1,   1,  1, 0,  0, 0, 0);
        add("t5_pll_hold",        0,  1,  0,   2,   1,  1, 0,  0, 0, 0);
        add("t5_pll_fall",        0,  1,  0,   1,   0,  1, 0,  0, 0, 0);
        add("t5_pre_relock",      0,  1,  0,   8,   0,  1, 0,  0, 0, 0);
        add("t5_relock",          0,  1,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t2_reset",           1,  0,  0,   1,   1,  1, 0,  0, 0, 0);
        add("t2_wait",            0,  0,  0,  23,   0,  1, 0,  0, 0, 0);
        add("t2_retry_pulse",     0,  0,  0,   1,   1,  1, 0,  0, 0, 1);
        add("t2_pulse_hold",      0,  0,  0,   3,   1,  1, 0,  0, 0, 1);
        add("t2_pulse_end",       0,  0,  0,   1,   0,  1, 0,  0, 0, 1);
        add("t2_pre_ready",       0,  1,  0,  10,   0,  1, 0,  0, 0, 1);
        add("t2_ready",           0,  1,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t3_reset",           1,  0,  0,   1,   1,  1, 0,  0, 0, 0);
        add("t3_retry1",          0,  0,  0,  24,   1,  1, 0,  0, 0, 1);
        add("t3_retry2",          0,  0,  0,  24,   1,  1, 0,  0, 0, 2);
        add("t3_last_wait",       0,  0,  0,  23,   0,  1, 0,  0, 0, 2);
        add("t3_fail",            0,  0,  0,   1,   1,  1, 0,  1, 0, 2);
        add("t3_fail_hold",       0,  0,  0,  50,   1,  1, 0,  1, 0, 2);
        add("t3_fail_lock_ign",   0,  1,  0,   5,   1,  1, 0,  1, 0, 2);
        add("t3_restart",         0,  0,  1,   1,   1,  1, 0,  0, 0, 0);
        add("t3_new_pulse",       0,  0,  0,   3,   1,  1, 0,  0, 0, 0);
        add("t3_pulse_end",       0,  0,  0,   1,   0,  1, 0,  0, 0, 0);
        add("t4_reset",           1,  0,  0,   1,   1,  1, 0,  0, 0, 0);
        add("t4_wait",            0,  0,  0,   4,   0,  1, 0,  0, 0, 0);
        add("t4_lock_a",          0,  1,  0,   5,   0,  1, 0,  0, 0, 0);
        add("t4_drop",            0,  0,  0,   2,   0,  1, 0,  0, 0, 0);
        add("t4_pre_ready",       0,  1,  0,  10,   0,  1, 0,  0, 0, 0);
        add("t4_ready",           0,  1,  0,   1,   0,  0, 1,  0, 0, 0);
        add("t6_reset",           1,  0,  0,   1,   1,  1, 0,  0, 0, 0);
        add("t6_stabilize",       0,  1,  0,   7,   0,  1, 0,  0, 0, 0);
        add("t6_rst_and_restart", 1,  1,  1,   1,   1,  1, 0,  0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            locked  = vecs[i].locked;
            restart = vecs[i].restart;
            step(vecs[i].cycles);
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Lock-loss latency measured from the raw input edge.
        rst = 1'b1; locked = 1'b0; restart = 1'b0;
        step(1);
        rst = 1'b0; locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            step(1);
            n++;
        end
        check("t7_reach_run", 32'(ready), 32'd1);
        locked = 1'b0;
        n = 0;
        do begin
            step(1);
            n++;
        end while (ready && n < 10);
        check("t7_ready_latency", n, 32'd3);
        check("t7_lock_lost_pulse", 32'({lock_lost, domain_rst, pll_rst}), 32'b111);

        // Restart alone in RUN must not raise lock_lost.
        locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            step(1);
            n++;
        end
        check("t7_relock_run", 32'(ready), 32'd1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("t7_restart_in_run", 32'(outs()), 32'(9'b1_1_0_0_0_0000));
        step(1);
        check("t7_restart_no_lost", 32'({pll_rst, lock_lost, ready}), 32'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpu_pll_supervisor.md
# gpu_pll_supervisor

Control-side counterpart of the GPU PLL: drives the PLL's reset input and consumes its `locked` output. It sequences PLL reset pulses, qualifies lock over a stable window, retries on lock timeout, and holds the downstream GPU/video domain in reset until lock is trustworthy. It runs on the 50 MHz reference clock and feeds `domain_rst`/`ready` to the SoC reset fabric.

## Interface
Parameters:
- `RESET_CYCLES`, 16: width of each `pll_rst` pulse in refclk cycles (≥1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock after a pulse (1 ms at 50 MHz, ≥1).
- `LOCK_STABLE`, 256: consecutive synchronized-locked cycles required before release (≥1).
- `RETRY_LIMIT`, 3: timeouts tolerated before `fail` (0..15).

Ports:
- `refclk` in 1: the only clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock, asynchronous to refclk; 2-flop synchronized internally (`locked_s`).
- `restart` in 1: single-cycle request to restart sequencing from any state.
- `pll_rst` out 1: drives the PLL reset input.
- `domain_rst` out 1: reset for the PLL-clocked domain, high until RUN.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAILED.
- `lock_lost` out 1: one-cycle pulse on loss of lock while in RUN.
- `retry_count` out 4: timeouts since the last RUN entry or restart.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAILED. Single shared cycle counter, width `$clog2` of the largest parameter + 1.
- All outputs are registered and change on the same edge as the state change.
- Priority: `rst` > `restart` > state logic.
- On `rst`: RESET_PLL, cnt=0, `pll_rst`=1, `domain_rst`=1, `ready`=0, `fail`=0, `lock_lost`=0, `retry_count`=0, sync flops=0.
- `restart`, in any state including FAILED: go to RESET_PLL, cnt=0, `retry_count`=0.
- RESET_PLL: `pll_rst`=1. When cnt==RESET_CYCLES-1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK: `pll_rst`=0.
  - `locked_s`=1: go to STABILIZE, cnt=0.
  - Else, when cnt==LOCK_TIMEOUT-1: if `retry_count`==RETRY_LIMIT, go to FAILED; otherwise increment `retry_count` and go to RESET_PLL with cnt=0.
- STABILIZE:
  - `locked_s`=0: go back to WAIT_LOCK with cnt=0 (full timeout restarts; `retry_count` unchanged).
  - When cnt==LOCK_STABLE-1 with `locked_s`=1: go to RUN and clear `retry_count`.
- RUN: `domain_rst`=0, `ready`=1. If `locked_s`=0: `lock_lost`=1 for exactly one cycle, then RESET_PLL, cnt=0, `domain_rst`=1 and `ready`=0 on that same edge.
- FAILED: `pll_rst`=1 (PLL held in reset), `domain_rst`=1, `fail`=1. Sticky; exit only via `rst` or `restart`.
- `locked` glitches shorter than one refclk cycle may be missed; no debounce beyond the STABILIZE window.

## Timing
- Sync latency: `locked` → `locked_s` takes 2 refclk edges.
- After `rst` falls, `pll_rst` stays high exactly RESET_CYCLES cycles.
- If `locked_s` is first seen high in WAIT_LOCK at cycle k and holds, `ready`/`domain_rst` change at cycle k+LOCK_STABLE+1.
- Timeout: RESET_PLL → WAIT_LOCK → next RESET_PLL period = RESET_CYCLES+LOCK_TIMEOUT cycles.
- FAILED is entered after (RETRY_LIMIT+1) unsuccessful waits.
- Lock loss in RUN: `ready` falls 3 edges after raw `locked` falls (2 sync + 1 state).

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, RETRY_LIMIT=2.

1. **Clean lock.** Release `rst`; raise `locked` 5 cycles after `pll_rst` falls. Required: `pll_rst` high exactly 4 cycles; `ready`=1 and `domain_rst`=0 exactly 2+8+1 cycles after `locked` rises; `retry_count`=0.
2. **Retry then lock.** Hold `locked`=0 through one timeout, then raise it. Required: second `pll_rst` pulse of 4 cycles starts 24 cycles after the first; `retry_count`=1 until RUN, then 0.
3. **Permanent failure.** `locked` held at 0. Required: 3 pulses, `retry_count` steps 1, 2, then `fail`=1 with `pll_rst`=1 and `ready`=0, holding indefinitely. Then pulse `restart`: `fail`=0, `retry_count`=0, new 4-cycle pulse begins.
4. **Stabilize abort.** `locked` high 5 cycles, low 2, then high. Required: no `ready` before 8 consecutive `locked_s` cycles; `retry_count` unchanged.
5. **Lock loss in RUN.** Drop `locked` for 1 cycle while in RUN. Required: `lock_lost` single pulse, `ready` falls and `domain_rst` rises on the same edge, new 4-cycle `pll_rst` pulse, then re-lock to RUN.
6. **Priority.** Assert `rst` and `restart` together mid-STABILIZE. Required: reset values on the next edge. Assert `restart` alone in RUN: RESET_PLL next edge, `ready`=0, `lock_lost` stays 0.
